// File: rtl/pipe_elastic_stage_pkg.sv
// Shared definitions for the elastic inter-stage buffers: payload types,
// payload width helpers and the wrapping pointer increment.
package pipe_elastic_stage_pkg;

    typedef logic [63:0] word_t;

    typedef struct packed {
        word_t      alu_result;
        word_t      store_data;
        logic [4:0] rd;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
    } xm_payload_t;

    typedef struct packed {
        word_t      result;
        logic [4:0] rd;
        logic       reg_write;
    } mw_payload_t;

    // Stage owners set DATA_W from these so the buffer tracks struct edits.
    function automatic int xm_width();
        return $bits(xm_payload_t);
    endfunction

    function automatic int mw_width();
        return $bits(mw_payload_t);
    endfunction

    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/pipe_elastic_stage_if.sv
// One valid/ready/data channel; the producer side uses master, the consumer slave.
interface pipe_elastic_stage_if #(
    parameter int DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_elastic_stage.sv
// DEPTH-entry elastic buffer between two pipeline stages with valid/ready on
// both sides, synchronous flush and occupancy output.
module pipe_elastic_stage
    import pipe_elastic_stage_pkg::*;
#(
    parameter int DATA_W        = 64,
    parameter int DEPTH         = 2,
    parameter bit ZERO_ON_EMPTY = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    pipe_elastic_stage_if.slave        i_in,
    pipe_elastic_stage_if.master       o_out,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    // in_ready looks only at the count register, so there is no out_ready -> in_ready path.
    assign w_in_ready  = (r_count < CNT_W'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_push      = i_in.valid & w_in_ready & ~i_flush;
    assign w_pop       = w_out_valid & o_out.ready & ~i_flush;

    assign i_in.ready  = w_in_ready;
    assign o_out.valid = w_out_valid;
    assign o_out.data  = (ZERO_ON_EMPTY && !w_out_valid) ? '0 : r_mem[r_rd_ptr];
    assign o_count     = r_count;

    // NOTE: payload storage has no reset; an empty buffer never exposes it.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_in.data;
        end
    end

    // NOTE: all state here uses <= so every read sees the pre-edge value.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= PTR_W'(ptr_inc(int'(r_wr_ptr), DEPTH));
            end
            if (w_pop) begin
                r_rd_ptr <= PTR_W'(ptr_inc(int'(r_rd_ptr), DEPTH));
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_count_bound: assert property (@(posedge i_clk) disable iff (i_rst)
        r_count <= CNT_W'(DEPTH));

    a_no_push_full: assert property (@(posedge i_clk) disable iff (i_rst)
        !(w_push && (r_count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Directed scoreboard bench driving DEPTH=1/2/3 instances with shared stimulus;
// the instance selected by sel is checked against a queue model each cycle.
module tb_pipe_elastic_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_data;

    always #5 clk = ~clk;

    pipe_elastic_stage_if #(.DATA_W(8)) in1 ();
    pipe_elastic_stage_if #(.DATA_W(8)) out1 ();
    pipe_elastic_stage_if #(.DATA_W(8)) in2 ();
    pipe_elastic_stage_if #(.DATA_W(8)) out2 ();
    pipe_elastic_stage_if #(.DATA_W(8)) in3 ();
    pipe_elastic_stage_if #(.DATA_W(8)) out3 ();

    assign in1.valid  = in_valid;
    assign in1.data   = in_data;
    assign out1.ready = out_ready;
    assign in2.valid  = in_valid;
    assign in2.data   = in_data;
    assign out2.ready = out_ready;
    assign in3.valid  = in_valid;
    assign in3.data   = in_data;
    assign out3.ready = out_ready;

    logic [0:0] cnt1;
    logic [1:0] cnt2;
    logic [1:0] cnt3;

    pipe_elastic_stage #(.DATA_W(8), .DEPTH(1), .ZERO_ON_EMPTY(1'b1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_in(in1), .o_out(out1), .o_count(cnt1));
    pipe_elastic_stage #(.DATA_W(8), .DEPTH(2), .ZERO_ON_EMPTY(1'b1)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_in(in2), .o_out(out2), .o_count(cnt2));
    pipe_elastic_stage #(.DATA_W(8), .DEPTH(3), .ZERO_ON_EMPTY(1'b1)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_in(in3), .o_out(out3), .o_count(cnt3));

    int         sel;
    logic [7:0] sb [$];
    int         checks = 0;
    int         passed = 0;
    int         fails  = 0;
    bit         toggle_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s (depth %0d): observed %0h expected %0h", tag, sel, got, exp);
        end
    endtask

    // One clock: check the selected instance at negedge, update the model with
    // the handshakes the coming edge will perform, then move past the edge.
    task automatic step(output bit acc);
        logic       o_ready;
        logic       o_valid;
        logic [7:0] o_data;
        int         o_count;
        bit         model_ready;
        logic [7:0] exp;
        @(negedge clk);
        case (sel)
            1:       begin o_ready = in1.ready; o_valid = out1.valid; o_data = out1.data; o_count = int'(cnt1); end
            2:       begin o_ready = in2.ready; o_valid = out2.valid; o_data = out2.data; o_count = int'(cnt2); end
            default: begin o_ready = in3.ready; o_valid = out3.valid; o_data = out3.data; o_count = int'(cnt3); end
        endcase
        model_ready = (sb.size() < sel);
        chk("count", 32'(o_count), 32'(sb.size()));
        chk("in_ready", 32'(o_ready), 32'(model_ready));
        chk("out_valid", 32'(o_valid), 32'(sb.size() != 0));
        if (sb.size() == 0) chk("out_data_zero", 32'(o_data), 32'h0);
        acc = 1'b0;
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (sb.size() != 0 && out_ready) begin
                exp = sb.pop_front();
                chk("out_data", 32'(o_data), 32'(exp));
            end
            if (in_valid && model_ready) begin
                sb.push_back(in_data);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (toggle_en) out_ready = ~out_ready;
    endtask

    task automatic send(input logic [7:0] d);
        bit acc;
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 20 && !done; i++) begin
            step(acc);
            done = acc;
        end
        if (!done) chk("send_timeout", 32'h0, 32'h1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic reset_all();
        bit acc;
        rst      = 1'b1;
        in_valid = 1'b0;
        step(acc);
        rst = 1'b0;
    endtask

    initial begin
        bit acc;
        int accepted;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        out_ready = 1'b1;
        sel       = 2;

        // Reset held two cycles with a beat offered: nothing may enter.
        step(acc);
        step(acc);
        rst      = 1'b0;
        in_valid = 1'b0;
        idle(2);

        // Streaming through DEPTH=2 with downstream always ready.
        send(8'h01);
        send(8'h02);
        send(8'h03);
        idle(2);

        // Back-pressure: fill, block the third beat, then release.
        out_ready = 1'b0;
        send(8'h10);
        send(8'h20);
        in_valid = 1'b1;
        in_data  = 8'h30;
        step(acc);
        out_ready = 1'b1;
        send(8'h30);
        idle(3);

        // DEPTH=3 pointer wrap with downstream ready toggling.
        sel = 3;
        reset_all();
        toggle_en = 1'b1;
        for (int i = 1; i <= 7; i++) send(8'(i));
        toggle_en = 1'b0;
        out_ready = 1'b1;
        idle(5);

        // Flush with two held entries and a beat offered in the same cycle.
        sel = 2;
        reset_all();
        out_ready = 1'b0;
        send(8'h41);
        send(8'h42);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        step(acc);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(3);

        // DEPTH=1 with both sides always willing: one beat every other cycle.
        sel = 1;
        reset_all();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hC0;
        accepted  = 0;
        for (int i = 0; i < 8; i++) begin
            step(acc);
            if (acc) begin
                accepted++;
                in_data = in_data + 8'h01;
            end
        end
        chk("depth1_accepts", 32'(accepted), 32'd4);
        idle(3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pipe_elastic_stage.md
Name: pipe_elastic_stage

Overview:
Parametrised, flow-controlled successor to the fixed inter-stage pipeline registers (X->M style). It carries an opaque payload of DATA_W bits between two pipeline stages through a DEPTH-entry elastic buffer. It uses valid/ready handshakes on both sides, a synchronous flush (replacing the ad-hoc bubble zeroing) and an occupancy output. The stage owner instantiates one per stage boundary and packs its stage struct into in_data / out_data.

Parameters:
DATA_W, 64, payload width in bits (>=1)
DEPTH, 2, buffer entries (>=1; power of two not required)
ZERO_ON_EMPTY, 1, 1: out_data driven to all-zero while out_valid=0; 0: out_data = stale head entry

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous squash of all held entries and the incoming beat
in_valid  in  1  upstream beat present
in_ready  out  1  stage can accept a beat this cycle
in_data  in  DATA_W  upstream payload
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head this cycle
out_data  out  DATA_W  head payload
count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH x DATA_W register array; wr_ptr, rd_ptr in 0..DEPTH-1, each wrapping DEPTH-1 -> 0; count register.
- in_ready = (count < DEPTH). It is a function of registered state only, with no combinational path from out_ready.
- out_valid = (count != 0). out_data = mem[rd_ptr], or 0 if empty and ZERO_ON_EMPTY=1.
- push = in_valid & in_ready & ~flush. pop = out_valid & out_ready & ~flush.
- On push: mem[wr_ptr] <= in_data and wr_ptr advances. On pop: rd_ptr advances.
- count next value: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a beat accepted at edge N appears on out_data after edge N if the buffer was empty. There is no combinational in->out bypass.
- Throughput: one beat/cycle sustained for DEPTH>=2. DEPTH=1 only passes a beat/cycle when that cycle's pop frees the slot. Because in_ready ignores pop, a full single entry blocks push in the same cycle, giving 50% throughput. This is accepted and documented.
- Full (count=DEPTH) with out_ready=1: pop occurs, push blocked this cycle, in_ready rises next cycle.
- Empty with in_valid=1 and out_ready=1: push only, no pop (out_valid=0).
- Flush: at the next edge wr_ptr=rd_ptr=0 and count=0. The incoming beat is dropped even if in_valid=1, and no pop is counted. The upstream sees in_ready per the pre-flush count, but the beat is discarded; upstream must treat flush as a squash.
- rst: same effect as flush and has priority over everything. Memory contents are not cleared (not observable when ZERO_ON_EMPTY=1).
- Reset values: out_valid=0, count=0, in_ready=1, out_data=0 (when ZERO_ON_EMPTY=1).
- rst or flush mid-stream: all in-flight beats are lost, and output is empty the cycle after the edge.
- No overflow or underflow is possible by construction. Simulation assertions required: count<=DEPTH, and no push when count==DEPTH.

Decomposition:
- Shared definitions package: typedef Signal, the stage payload structs (e.g. XM/MW payloads), and a helper function returning the packed width of each payload so instantiations set DATA_W from the package.
- A pointer/counter helper belongs in the package as a function: ptr_inc(ptr, DEPTH) with explicit wrap.
- No sub-module; a single module of storage, two pointers and a counter.

Test Plan:
1. rst=1 for 2 cycles with in_valid=1, in_data=0xAA -> out_valid=0, count=0, in_ready=1, out_data=0 throughout and after release.
2. DEPTH=2, out_ready=1, push 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on the following consecutive cycles, count stays 1, no stall.
3. DEPTH=2, out_ready=0, push 0x10,0x20,0x30 -> count=2, in_ready=0 at the third beat, 0x30 not accepted. Raise out_ready -> 0x10 then 0x20 emerge, and 0x30 is accepted once in_ready=1.
4. DEPTH=3 wrap: repeatedly push 7 beats 0x1..0x7 with out_ready toggling 1,0,1,0 -> output order exactly 0x1..0x7, pointers wrap 2->0 with no loss or duplication.
5. Hold 2 entries, assert flush with in_valid=1, in_data=0x55 -> next cycle count=0, out_valid=0, out_data=0, and 0x55 never appears.
6. DEPTH=1, in_valid=1 and out_ready=1 constantly -> accepted beats alternate cycles (50%), order preserved, count alternates 1/0.
